// File: rtl/aurora_params.sv
// Shared sizing for the Aurora TX packer: default frame/timeout limits and the
// beat record used for the one-deep pending stage.
package aurora_params;

  localparam int PACK_FRAME_BEATS   = 64;
  localparam int PACK_FLUSH_TIMEOUT = 256;

  localparam int LANES    = 4;
  localparam int SAMPLE_W = 32;
  localparam int BEAT_W   = LANES * SAMPLE_W;
  localparam int KEEP_W   = BEAT_W / 8;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

endpackage

// File: rtl/aurora_tx_packer.sv
// Packs 32-bit samples into 128-bit Aurora beats; frames close on i_tlast,
// on FRAME_BEATS beats, or on an idle timeout (reported via stat_flush).
module aurora_tx_packer
  import aurora_params::*;
#(
  parameter int FRAME_BEATS   = PACK_FRAME_BEATS,
  parameter int FLUSH_TIMEOUT = PACK_FLUSH_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] i_tdata,
  input  logic                i_tvalid,
  input  logic                i_tlast,
  output logic                i_tready,
  output logic [BEAT_W-1:0]   o_tdata,
  output logic [KEEP_W-1:0]   o_tkeep,
  output logic                o_tvalid,
  output logic                o_tlast,
  input  logic                o_tready,
  output logic                stat_flush
);

  localparam int TIMER_W    = $clog2(FLUSH_TIMEOUT + 1);
  localparam int BEAT_CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [TIMER_W-1:0]    TIMER_MAX = TIMER_W'(FLUSH_TIMEOUT);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(FRAME_BEATS - 1);

  function automatic logic [KEEP_W-1:0] keep_of(input logic [2:0] n);
    keep_of = '0;
    for (int k = 0; k < LANES; k++)
      if (3'(k) < n) keep_of[4*k +: 4] = 4'hF;
  endfunction

  logic [SAMPLE_W-1:0]   acc [0:LANES-2];
  logic [1:0]            lane;
  beat_t                 pend;
  logic                  pend_vld;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [TIMER_W-1:0]    timer;

  logic out_free, accept, beat_end, frame_end, open_frame, expired, drain, flush;
  logic [BEAT_W-1:0] asm_data;
  logic [BEAT_W-1:0] part_data;

  assign out_free   = !o_tvalid || o_tready;
  assign i_tready   = out_free;
  assign accept     = i_tvalid && out_free;
  assign beat_end   = (lane == 2'd3) || i_tlast;
  assign frame_end  = i_tlast || (beat_cnt == LAST_BEAT);
  assign open_frame = (lane != 2'd0) || pend_vld;
  assign expired    = (timer == TIMER_MAX);
  // A frame-ending beat parked behind a held beat drains on its own.
  assign drain      = pend_vld && pend.last && out_free && !accept;
  assign flush      = expired && out_free && !accept && !drain;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    asm_data  = '0;
    part_data = '0;
    for (int k = 0; k < LANES - 1; k++) begin
      if (2'(k) < lane) begin
        asm_data[k*SAMPLE_W +: SAMPLE_W]  = acc[k];
        part_data[k*SAMPLE_W +: SAMPLE_W] = acc[k];
      end
    end
    asm_data[lane*SAMPLE_W +: SAMPLE_W] = i_tdata;
  end

  // NOTE: sample storage carries no reset; lane alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (accept && !beat_end) acc[lane] <= i_tdata;
  end

  // NOTE: state updates use <= so every branch below sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_tvalid   <= 1'b0;
      o_tlast    <= 1'b0;
      o_tdata    <= '0;
      o_tkeep    <= '0;
      stat_flush <= 1'b0;
      lane       <= '0;
      beat_cnt   <= '0;
      timer      <= '0;
      pend       <= '0;
      pend_vld   <= 1'b0;
    end else begin
      stat_flush <= 1'b0;
      if (o_tvalid && o_tready) o_tvalid <= 1'b0;

      if (accept) begin
        timer <= '0;
        if (pend_vld) begin
          {o_tdata, o_tkeep, o_tlast} <= pend;
          o_tvalid <= 1'b1;
          pend_vld <= 1'b0;
        end
        if (beat_end) begin
          lane <= '0;
          if (frame_end) begin
            beat_cnt <= '0;
            if (pend_vld) begin
              pend     <= '{data: asm_data, keep: keep_of({1'b0, lane} + 3'd1), last: 1'b1};
              pend_vld <= 1'b1;
            end else begin
              o_tdata  <= asm_data;
              o_tkeep  <= keep_of({1'b0, lane} + 3'd1);
              o_tlast  <= 1'b1;
              o_tvalid <= 1'b1;
            end
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            pend     <= '{data: asm_data, keep: '1, last: 1'b0};
            pend_vld <= 1'b1;
          end
        end else begin
          lane <= lane + 2'd1;
        end
      end else if (drain) begin
        {o_tdata, o_tkeep, o_tlast} <= pend;
        o_tvalid <= 1'b1;
        pend_vld <= 1'b0;
        timer    <= '0;
      end else if (flush) begin
        if (pend_vld) begin
          o_tdata <= pend.data;
          o_tkeep <= pend.keep;
        end else begin
          o_tdata <= part_data;
          o_tkeep <= keep_of({1'b0, lane});
        end
        o_tlast    <= 1'b1;
        o_tvalid   <= 1'b1;
        pend_vld   <= 1'b0;
        lane       <= '0;
        beat_cnt   <= '0;
        timer      <= '0;
        stat_flush <= 1'b1;
      end else if (!open_frame) begin
        timer <= '0;
      end else if (!expired) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aurora_tx_packer.sv
// Self-checking bench for aurora_tx_packer: directed scenarios plus a random
// stream compared against a sample-level packing model.
module tb_aurora_tx_packer;

  localparam int FB = 4;
  localparam int FT = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  i_tdata = '0;
  logic         i_tvalid = 1'b0;
  logic         i_tlast = 1'b0;
  logic         i_tready;
  logic [127:0] o_tdata;
  logic [15:0]  o_tkeep;
  logic         o_tvalid;
  logic         o_tlast;
  logic         o_tready = 1'b0;
  logic         stat_flush;

  aurora_tx_packer #(.FRAME_BEATS(FB), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tkeep(o_tkeep), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .stat_flush(stat_flush)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    int           cyc;
  } obs_t;

  obs_t got[$];
  obs_t exp_q[$];
  int   flush_cnt = 0;
  int   flush_cyc = -1;
  logic rand_ready = 1'b0;

  // Monitor: inputs change just after posedge, so negedge values are the handshake values.
  logic         prev_blk = 1'b0;
  logic [144:0] prev_out;
  always @(negedge clk) begin
    if (rst) begin
      prev_blk = 1'b0;
    end else begin
      if (prev_blk) begin
        total_cnt++;
        if ({o_tvalid, o_tdata, o_tkeep, o_tlast} !== {1'b1, prev_out})
          $display("FAIL stall_stability: got v=%0b %h/%h/%0b want %h", o_tvalid, o_tdata, o_tkeep, o_tlast, prev_out);
        else pass_cnt++;
      end
      if (o_tvalid) begin
        total_cnt++;
        if (o_tkeep === 16'h0) $display("FAIL empty_beat: tkeep=%h want nonzero", o_tkeep);
        else pass_cnt++;
      end
      if (o_tvalid && o_tready) got.push_back('{o_tdata, o_tkeep, o_tlast, cyc});
      if (stat_flush) begin
        flush_cnt++;
        flush_cyc = cyc;
      end
      prev_blk = o_tvalid && !o_tready;
      prev_out = {o_tdata, o_tkeep, o_tlast};
    end
  end

  // Packing model: works purely on the sample stream, beat and frame boundaries.
  logic [127:0] m_data = '0;
  int           m_n = 0;
  int           m_beats = 0;

  task automatic model_push(input logic [31:0] d, input logic l);
    obs_t b;
    m_data[m_n*32 +: 32] = d;
    m_n++;
    if (m_n == 4 || l) begin
      b.data = m_data;
      b.keep = 16'hFFFF >> (16 - 4*m_n);
      b.last = l || (m_beats == FB - 1);
      b.cyc  = 0;
      exp_q.push_back(b);
      m_beats = b.last ? 0 : m_beats + 1;
      m_n = 0;
      m_data = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) o_tready = ($urandom_range(0, 3) != 0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic l, output int e);
    int n;
    n = 0;
    i_tdata = d;
    i_tvalid = 1'b1;
    i_tlast = l;
    #1;
    while (!i_tready && n < 200) begin
      tick();
      #1;
      n++;
    end
    total_cnt++;
    if (!i_tready) begin
      $display("FAIL accept_timeout: i_tready=%0b want 1 within %0d cycles", i_tready, n);
      e = -1;
    end else begin
      pass_cnt++;
      e = cyc + 1;
    end
    tick();
    i_tvalid = 1'b0;
    i_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({o_tvalid, o_tlast, stat_flush, i_tready} !== 4'b0001)
      $display("FAIL reset_ctrl: got v/l/f/rdy=%b want 0001", {o_tvalid, o_tlast, stat_flush, i_tready});
    else pass_cnt++;
    total_cnt++;
    if (o_tdata !== 128'h0 || o_tkeep !== 16'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", o_tdata, o_tkeep);
    else pass_cnt++;
    rst = 1'b0;
    o_tready = 1'b1;
    tick();
  endtask

  task automatic test_end_of_burst();
    int e[8];
    got.delete();
    for (int i = 0; i < 8; i++) send(32'(i + 1), i == 7, e[i]);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != 2) $display("FAIL eob_count: got %0d beats want 2", got.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (got[0].data !== {32'h4, 32'h3, 32'h2, 32'h1} || got[0].keep !== 16'hFFFF || got[0].last !== 1'b0 || got[0].cyc != e[4])
        $display("FAIL eob_beat1: got %h/%h/%0b@%0d want 00000004000000030000000200000001/ffff/0@%0d",
                 got[0].data, got[0].keep, got[0].last, got[0].cyc, e[4]);
      else pass_cnt++;
      total_cnt++;
      if (got[1].data !== {32'h8, 32'h7, 32'h6, 32'h5} || got[1].keep !== 16'hFFFF || got[1].last !== 1'b1 || got[1].cyc != e[7])
        $display("FAIL eob_beat2: got %h/%h/%0b@%0d want 00000008000000070000000600000005/ffff/1@%0d",
                 got[1].data, got[1].keep, got[1].last, got[1].cyc, e[7]);
      else pass_cnt++;
    end
    total_cnt++;
    if (e[7] - e[0] != 7) $display("FAIL eob_throughput: got %0d cycles for 8 samples want 7", e[7] - e[0]);
    else pass_cnt++;
  endtask

  task automatic test_partial_tlast();
    int ea, eb;
    got.delete();
    send(32'hA, 1'b0, ea);
    send(32'hB, 1'b1, eb);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != 1) $display("FAIL partial_count: got %0d beats want 1", got.size());
    else if (got[0].data !== {64'h0, 32'hB, 32'hA} || got[0].keep !== 16'h00FF || got[0].last !== 1'b1 || got[0].cyc != eb)
      $display("FAIL partial_beat: got %h/%h/%0b@%0d want ..0000000b0000000a/00ff/1@%0d",
               got[0].data, got[0].keep, got[0].last, got[0].cyc, eb);
    else pass_cnt++;
  endtask

  task automatic test_max_length();
    int e[20];
    logic [127:0] d;
    int want_cyc;
    got.delete();
    flush_cnt = 0;
    for (int i = 0; i < 20; i++) send(32'h100 + 32'(i), 1'b0, e[i]);
    repeat (FT + 6) tick();
    total_cnt++;
    if (got.size() != 5) $display("FAIL maxlen_count: got %0d beats want 5", got.size());
    else begin
      pass_cnt++;
      for (int j = 0; j < 5; j++) begin
        for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'h100 + 32'(4*j + k);
        want_cyc = (j < 3) ? e[4*j + 4] : (j == 3) ? e[15] : e[19] + FT + 1;
        total_cnt++;
        if (got[j].data !== d || got[j].keep !== 16'hFFFF || got[j].last !== (j >= 3) || got[j].cyc != want_cyc)
          $display("FAIL maxlen_beat%0d: got %h/%h/%0b@%0d want %h/ffff/%0b@%0d",
                   j, got[j].data, got[j].keep, got[j].last, got[j].cyc, d, j >= 3, want_cyc);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (flush_cnt != 1) $display("FAIL maxlen_flushes: got %0d want 1", flush_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int e[3];
    got.delete();
    flush_cnt = 0;
    send(32'h11, 1'b0, e[0]);
    send(32'h22, 1'b0, e[1]);
    send(32'h33, 1'b0, e[2]);
    repeat (FT + 6) tick();
    total_cnt++;
    if (got.size() != 1) $display("FAIL timeout_count: got %0d beats want 1", got.size());
    else if (got[0].data !== {32'h0, 32'h33, 32'h22, 32'h11} || got[0].keep !== 16'h0FFF || got[0].last !== 1'b1 || got[0].cyc != e[2] + FT + 1)
      $display("FAIL timeout_beat: got %h/%h/%0b@%0d want ..000000330000002200000011/0fff/1@%0d",
               got[0].data, got[0].keep, got[0].last, got[0].cyc, e[2] + FT + 1);
    else pass_cnt++;
    total_cnt++;
    if (flush_cnt != 1 || flush_cyc != e[2] + FT + 1)
      $display("FAIL timeout_stat: got %0d pulses @%0d want 1 @%0d", flush_cnt, flush_cyc, e[2] + FT + 1);
    else pass_cnt++;
  endtask

  task automatic test_backpressure_race();
    int e[6];
    got.delete();
    flush_cnt = 0;
    for (int i = 0; i < 4; i++) send(32'(i + 1), 1'b0, e[i]);
    o_tready = 1'b0;
    send(32'h5, 1'b0, e[4]);
    repeat (30) begin
      tick();
      total_cnt++;
      if (i_tready !== 1'b0 || o_tvalid !== 1'b1 || stat_flush !== 1'b0)
        $display("FAIL stall_ctrl: got rdy/v/f=%b want 010", {i_tready, o_tvalid, stat_flush});
      else pass_cnt++;
    end
    o_tready = 1'b1;
    send(32'h6, 1'b1, e[5]);
    repeat (4) tick();
    total_cnt++;
    if (got.size() != 2) $display("FAIL race_count: got %0d beats want 2", got.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (got[0].data !== {32'h4, 32'h3, 32'h2, 32'h1} || got[0].keep !== 16'hFFFF || got[0].last !== 1'b0)
        $display("FAIL race_beat1: got %h/%h/%0b want 00000004000000030000000200000001/ffff/0",
                 got[0].data, got[0].keep, got[0].last);
      else pass_cnt++;
      total_cnt++;
      if (got[1].data !== {64'h0, 32'h6, 32'h5} || got[1].keep !== 16'h00FF || got[1].last !== 1'b1 || got[1].cyc != e[5])
        $display("FAIL race_beat2: got %h/%h/%0b@%0d want ..0000000600000005/00ff/1@%0d",
                 got[1].data, got[1].keep, got[1].last, got[1].cyc, e[5]);
      else pass_cnt++;
    end
    total_cnt++;
    if (flush_cnt != 0) $display("FAIL race_flush: got %0d pulses want 0", flush_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int e[6];
    for (int i = 0; i < 6; i++) send(32'h61 + 32'(i), 1'b0, e[i]);
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({o_tvalid, o_tlast, stat_flush, i_tready} !== 4'b0001 || o_tdata !== 128'h0 || o_tkeep !== 16'h0)
      $display("FAIL midrst_outputs: got v/l/f/rdy=%b data=%h keep=%h want 0001/0/0",
               {o_tvalid, o_tlast, stat_flush, i_tready}, o_tdata, o_tkeep);
    else pass_cnt++;
    got.delete();
    flush_cnt = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (FT + 10) tick();
    total_cnt++;
    if (got.size() != 0 || flush_cnt != 0)
      $display("FAIL midrst_residue: got %0d beats %0d flushes want 0/0", got.size(), flush_cnt);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int e;
    logic [31:0] d;
    logic l;
    int n;
    got.delete();
    exp_q.delete();
    flush_cnt = 0;
    m_data = '0;
    m_n = 0;
    m_beats = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      l = ($urandom_range(0, 5) == 0) || (i == 299);
      model_push(d, l);
      send(d, l, e);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    o_tready = 1'b1;
    repeat (10) tick();
    total_cnt++;
    if (got.size() != exp_q.size()) $display("FAIL rand_count: got %0d beats want %0d", got.size(), exp_q.size());
    else pass_cnt++;
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int j = 0; j < n; j++) begin
      total_cnt++;
      if (got[j].data !== exp_q[j].data || got[j].keep !== exp_q[j].keep || got[j].last !== exp_q[j].last)
        $display("FAIL rand_beat%0d: got %h/%h/%0b want %h/%h/%0b", j,
                 got[j].data, got[j].keep, got[j].last, exp_q[j].data, exp_q[j].keep, exp_q[j].last);
      else pass_cnt++;
    end
    total_cnt++;
    if (flush_cnt != 0) $display("FAIL rand_flush: got %0d pulses want 0", flush_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_end_of_burst();
    test_partial_tlast();
    test_max_length();
    test_timeout();
    test_backpressure_race();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
